// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue/capture sequencer and its users.
//   state_t    : sequencer FSM states (IDLE -> EXEC -> DONE -> IDLE)
//   MODE_*     : ALU mode encodings (arithmetic / logic)
//   SEL_*      : ALU function-select codes for the operations used by software
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    // SEL_SUB and SEL_XOR share an encoding; mode decides which one runs.
    localparam logic [3:0] SEL_ADD = 4'b1001;  // arithmetic mode
    localparam logic [3:0] SEL_SUB = 4'b0110;  // arithmetic mode
    localparam logic [3:0] SEL_XOR = 4'b0110;  // logic mode

endpackage : alu_pkg

// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Command and result handshakes of the ALU sequencer.
//   cmd_* : command channel (valid/ready), operands and function controls
//   res_* : result channel (valid/ready), captured result and status
//   res_zero exists only when ALU_SEQ_ZERO_FLAG_EN is defined.
// Modports:
//   master : command producer / result consumer
//   slave  : the sequencer
// -----------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [3:0]       cmd_select;
    logic             cmd_mode;
    logic             cmd_carry_in;
    logic             cmd_use_carry;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_compare;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic             res_zero;
`endif

    modport master (
`ifdef ALU_SEQ_ZERO_FLAG_EN
        input  res_zero,
`endif
        output cmd_valid, cmd_a, cmd_b, cmd_select, cmd_mode,
               cmd_carry_in, cmd_use_carry, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_compare
    );

    modport slave (
`ifdef ALU_SEQ_ZERO_FLAG_EN
        output res_zero,
`endif
        input  cmd_valid, cmd_a, cmd_b, cmd_select, cmd_mode,
               cmd_carry_in, cmd_use_carry, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_compare
    );

endinterface : alu_seq_if

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Issue/capture sequencer for the combinational 16-bit ALU. A command is
// registered onto the ALU inputs, the ALU outputs are captured one cycle
// later, and the result is held until the consumer takes it. A stored carry
// flag lets consecutive arithmetic commands chain for multi-word math.
//
// Optional feature: define ALU_SEQ_ZERO_FLAG_EN to add bus.res_zero
// (captured alu_result == 0).
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   bus           alu_seq_if.slave: cmd_* in, res_* out (valid/ready)
//   flag_clr      clear the stored carry flag at the next edge
//   alu_a/b       operands to the ALU
//   alu_select    ALU function select
//   alu_mode      ALU mode (0 arithmetic, 1 logic)
//   alu_carry_in  ALU carry-in
//   alu_result    ALU result
//   alu_carry_out ALU carry-out
//   alu_compare   ALU compare output
//   carry_flag    stored carry flag
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_if.slave         bus,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_select,
    output logic             alu_mode,
    output logic             alu_carry_in,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry_out,
    input  logic             alu_compare,
    output logic             carry_flag
);

    state_t state;

    // NOTE: every register here is ordinary state (no memory arrays), so all of
    // them are reset; non-blocking assignments keep each edge's reads seeing the
    // pre-edge values, which is what makes the flag_clr / use_carry case work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bus.cmd_ready   <= 1'b1;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_select      <= '0;
            alu_mode        <= 1'b0;
            alu_carry_in    <= 1'b0;
            bus.res_valid   <= 1'b0;
            bus.res_data    <= '0;
            bus.res_carry   <= 1'b0;
            bus.res_compare <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            bus.res_zero    <= 1'b0;
`endif
            carry_flag      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        alu_a        <= bus.cmd_a;
                        alu_b        <= bus.cmd_b;
                        alu_select   <= bus.cmd_select;
                        alu_mode     <= bus.cmd_mode;
                        // Flag read here is the pre-edge value, so a flag_clr in
                        // this same cycle does not affect this command.
                        alu_carry_in <= bus.cmd_use_carry ? carry_flag
                                                          : bus.cmd_carry_in;
                        bus.cmd_ready <= 1'b0;
                        state         <= EXEC;
                    end
                end

                EXEC: begin
                    // ALU is combinational: its outputs already reflect alu_*.
                    bus.res_data    <= alu_result;
                    bus.res_carry   <= (alu_mode == MODE_ARITH) && alu_carry_out;
                    bus.res_compare <= alu_compare;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    bus.res_zero    <= (alu_result == '0);
`endif
                    bus.res_valid   <= 1'b1;
                    if (alu_mode == MODE_ARITH) begin
                        carry_flag <= alu_carry_out;
                    end
                    state <= DONE;
                end

                DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.res_valid <= 1'b0;
                end
            endcase

            // Placed after the FSM so the clear overrides an EXEC update.
            if (flag_clr) begin
                carry_flag <= 1'b0;
            end
        end
    end

endmodule : alu_seq

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Directed bench for alu_seq. A small behavioural ALU closes the loop on the
// alu_* ports; a vector table drives chained commands, and hand-written
// sequences cover backpressure, reset in flight and flag_clr priority.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flag_clr = 1'b0;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_select;
    logic         alu_mode, alu_carry_in, alu_carry_out, alu_compare;
    logic         carry_flag;

    int total = 0;
    int bad   = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .flag_clr      (flag_clr),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_select    (alu_select),
        .alu_mode      (alu_mode),
        .alu_carry_in  (alu_carry_in),
        .alu_result    (alu_result),
        .alu_carry_out (alu_carry_out),
        .alu_compare   (alu_compare),
        .carry_flag    (carry_flag)
    );

    always #5 clk = ~clk;

    // Stand-in ALU. In logic mode it drives carry_out high so that the
    // sequencer's forcing of res_carry to 0 is observable.
    always_comb begin
        alu_result    = alu_a;
        alu_carry_out = 1'b0;
        alu_compare   = (alu_a == alu_b);
        if (alu_mode == MODE_ARITH) begin
            case (alu_select)
                SEL_ADD: {alu_carry_out, alu_result} =
                    {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_carry_in};
                SEL_SUB: {alu_carry_out, alu_result} =
                    {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, alu_carry_in};
                default: alu_result = alu_a;
            endcase
        end else begin
            alu_carry_out = 1'b1;
            case (alu_select)
                SEL_XOR: alu_result = alu_a ^ alu_b;
                default: alu_result = alu_a & alu_b;
            endcase
        end
    end

    typedef struct {
        logic         mode;
        logic [3:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         use_carry;
        logic         exp_cin;
        logic [W-1:0] exp_data;
        logic         exp_carry;
        logic         exp_cmp;
        logic         exp_flag;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input vec_t v);
        bus.cmd_valid     = 1'b1;
        bus.cmd_a         = v.a;
        bus.cmd_b         = v.b;
        bus.cmd_select    = v.sel;
        bus.cmd_mode      = v.mode;
        bus.cmd_carry_in  = v.cin;
        bus.cmd_use_carry = v.use_carry;
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, ".res_valid"}, W'(bus.res_valid), W'(1'b1));
        check({tag, ".res_data"}, bus.res_data, v.exp_data);
        check({tag, ".res_carry"}, W'(bus.res_carry), W'(v.exp_carry));
        check({tag, ".res_compare"}, W'(bus.res_compare), W'(v.exp_cmp));
        check({tag, ".carry_flag"}, W'(carry_flag), W'(v.exp_flag));
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check({tag, ".res_zero"}, W'(bus.res_zero), W'(v.exp_zero));
`endif
    endtask

    // Full transaction from IDLE: accept, EXEC, DONE, then consume.
    task automatic run_cmd(input string tag, input vec_t v);
        drive_cmd(v);
        tick();                               // acceptance edge
        bus.cmd_valid = 1'b0;
        check({tag, ".alu_carry_in"}, W'(alu_carry_in), W'(v.exp_cin));
        check({tag, ".valid_early"}, W'(bus.res_valid), W'(1'b0));
        check({tag, ".ready_busy"}, W'(bus.cmd_ready), W'(1'b0));
        tick();                               // EXEC capture edge
        check_result(tag, v);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({tag, ".valid_drop"}, W'(bus.res_valid), W'(1'b0));
        check({tag, ".ready_back"}, W'(bus.cmd_ready), W'(1'b1));
    endtask

    function automatic vec_t mk(input logic mode, input logic [3:0] sel,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic uc, input logic ecin,
                                input logic [W-1:0] d, input logic c,
                                input logic cmp, input logic f, input logic z);
        vec_t v;
        v = '{mode, sel, a, b, cin, uc, ecin, d, c, cmp, f, z};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;

        // Chained sequence; each row's flag expectation follows from the row above.
        //               mode        sel      a         b        cin   uc  ecin  data      carry cmp flag zero
        vecs[0] = mk(MODE_ARITH, SEL_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[1] = mk(MODE_ARITH, SEL_ADD, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[2] = mk(MODE_ARITH, SEL_ADD, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3] = mk(MODE_ARITH, SEL_SUB, 16'h0005, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[4] = mk(MODE_LOGIC, SEL_XOR, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[5] = mk(MODE_ARITH, SEL_SUB, 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[6] = mk(MODE_ARITH, SEL_ADD, 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h2468, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[7] = mk(MODE_ARITH, SEL_ADD, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[8] = mk(MODE_ARITH, SEL_ADD, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[9] = mk(MODE_LOGIC, SEL_XOR, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);

        bus.cmd_valid     = 1'b0;
        bus.cmd_a         = '0;
        bus.cmd_b         = '0;
        bus.cmd_select    = '0;
        bus.cmd_mode      = 1'b0;
        bus.cmd_carry_in  = 1'b0;
        bus.cmd_use_carry = 1'b0;
        bus.res_ready     = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst.cmd_ready", W'(bus.cmd_ready), W'(1'b1));
        check("rst.res_valid", W'(bus.res_valid), W'(1'b0));
        check("rst.res_data", bus.res_data, 16'h0000);
        check("rst.res_carry", W'(bus.res_carry), W'(1'b0));
        check("rst.carry_flag", W'(carry_flag), W'(1'b0));
        check("rst.alu_a", alu_a, 16'h0000);
        check("rst.alu_carry_in", W'(alu_carry_in), W'(1'b0));
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("rst.res_zero", W'(bus.res_zero), W'(1'b0));
`endif

        // A stray res_ready while nothing is pending must not disturb IDLE.
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("idle_res_ready.cmd_ready", W'(bus.cmd_ready), W'(1'b1));

        for (int i = 0; i < 10; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: result held, second command refused. Flag is 0 here.
        v = mk(MODE_ARITH, SEL_ADD, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cmd(v);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check_result("bp", v);
        drive_cmd(mk(MODE_ARITH, SEL_ADD, 16'h5555, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("bp%0d.res_valid", i), W'(bus.res_valid), W'(1'b1));
            check($sformatf("bp%0d.res_data", i), bus.res_data, 16'h0007);
            check($sformatf("bp%0d.cmd_ready", i), W'(bus.cmd_ready), W'(1'b0));
            check($sformatf("bp%0d.alu_a", i), alu_a, 16'h0003);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("bp.release_valid", W'(bus.res_valid), W'(1'b0));
        check("bp.release_ready", W'(bus.cmd_ready), W'(1'b1));

        // Reset during EXEC: set the flag first, then abort a command in flight.
        run_cmd("pre_rst", vecs[0]);
        drive_cmd(vecs[7]);
        tick();
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_exec.res_valid", W'(bus.res_valid), W'(1'b0));
        check("rst_exec.carry_flag", W'(carry_flag), W'(1'b0));
        check("rst_exec.cmd_ready", W'(bus.cmd_ready), W'(1'b1));
        check("rst_exec.res_data", bus.res_data, 16'h0000);
        tick();
        check("rst_exec.settled_valid", W'(bus.res_valid), W'(1'b0));

        // flag_clr coinciding with an EXEC carry-producing add: clear wins.
        drive_cmd(vecs[0]);
        tick();
        bus.cmd_valid = 1'b0;
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("clr_exec.res_carry", W'(bus.res_carry), W'(1'b1));
        check("clr_exec.res_data", bus.res_data, 16'h0000);
        check("clr_exec.carry_flag", W'(carry_flag), W'(1'b0));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        // flag_clr in IDLE with a use_carry accept: carry-in sees the old flag.
        run_cmd("pre_clr", vecs[0]);
        drive_cmd(vecs[1]);
        flag_clr = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        flag_clr = 1'b0;
        check("clr_idle.alu_carry_in", W'(alu_carry_in), W'(1'b1));
        check("clr_idle.carry_flag", W'(carry_flag), W'(1'b0));
        tick();
        check_result("clr_idle", vecs[1]);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        // flag_clr in DONE, without any EXEC update, clears the flag.
        v = vecs[0];
        drive_cmd(v);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check("clr_done.flag_set", W'(carry_flag), W'(1'b1));
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("clr_done.carry_flag", W'(carry_flag), W'(1'b0));
        check("clr_done.res_valid", W'(bus.res_valid), W'(1'b1));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_seq
